// File: rtl/zs_pkg.sv
// zs_pkg: shared constants for the zero-suppression scheduler.
//   POS_W_DEF  : default position width
//   NUM_SCALE  : number of classifier scales (23x23, 19x19, 17x17)
//   SCALE_*    : scale index used for per-scale vectors
//   state_t    : scheduler FSM encoding
package zs_pkg;

    localparam int POS_W_DEF = 13;
    localparam int NUM_SCALE = 3;

    localparam int SCALE_23 = 0;
    localparam int SCALE_19 = 1;
    localparam int SCALE_17 = 2;

    typedef enum logic {
        IDLE = 1'b0,
        WAIT = 1'b1
    } state_t;

endpackage

// File: rtl/zs_pos_fifo.sv
// zs_pos_fifo: DEPTH x W synchronous FIFO for detection positions.
// Ports:
//   clk, rst_n   : clock, async active-low reset
//   push, pop    : enqueue din / dequeue head (ignored when full / empty,
//                  except push on full is accepted when popping same cycle)
//   flush        : empty the FIFO; overrides push and pop
//   din          : write data
//   head         : oldest entry (valid when !empty)
//   count        : number of stored entries
//   full, empty  : status
module zs_pos_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 13
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       flush,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               head,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [CW-1:0] count_d;
    logic          pop_ok, push_ok;

    assign empty   = (count == '0);
    assign pop_ok  = pop & ~empty;
    assign push_ok = push & (~full | pop_ok);
    assign head    = mem[rd_ptr];

    always_comb begin
        count_d = count;
        if (flush)
            count_d = '0;
        else if (push_ok && !pop_ok)
            count_d = count + CW'(1);
        else if (pop_ok && !push_ok)
            count_d = count - CW'(1);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
        end else begin
            count <= count_d;
            full  <= (count_d == CW'(DEPTH));
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push_ok) wr_ptr <= wr_ptr + AW'(1);
                if (pop_ok)  rd_ptr <= rd_ptr + AW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read when count says valid.
    always_ff @(posedge clk) begin
        if (push_ok && !flush)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/zs_scheduler.sv
// zs_scheduler: buffers per-scale detections and issues them to the zs
// block in batches (all non-empty FIFO heads at once), waiting for the
// zs finish pulse (or a timeout) between batches.
// Ports:
//   iClk, iReset_n            : clock, async active-low reset (sync release)
//   iDet_valid_*/iDet_pos_*   : per-scale detection strobe and position
//   oDet_full_*               : per-scale FIFO full
//   iFlush                    : frame-boundary clear (FIFOs, sticky flags)
//   oInput_ready_*/oPosition_*: 1-cycle zs request pulse and position
//   iZs_finish                : zs completion pulse
//   oBusy                     : FSM waiting or any FIFO non-empty
//   oOverflow[2:0]            : sticky drop flags (bit0 23x23 .. bit2 17x17)
//   oTimeout                  : sticky, zs missed the finish deadline
// Build option: ZS_SCHED_DEDUP_EN drops a push equal to the last accepted
// position of the same scale.
module zs_scheduler
    import zs_pkg::*;
#(
    parameter int POS_W       = POS_W_DEF,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 8192
) (
    input  logic             iClk,
    input  logic             iReset_n,
    input  logic             iDet_valid_23x23,
    input  logic             iDet_valid_19x19,
    input  logic             iDet_valid_17x17,
    input  logic [POS_W-1:0] iDet_pos_23x23,
    input  logic [POS_W-1:0] iDet_pos_19x19,
    input  logic [POS_W-1:0] iDet_pos_17x17,
    output logic             oDet_full_23x23,
    output logic             oDet_full_19x19,
    output logic             oDet_full_17x17,
    input  logic             iFlush,
    output logic             oInput_ready_23x23,
    output logic             oInput_ready_19x19,
    output logic             oInput_ready_17x17,
    output logic [POS_W-1:0] oPosition_23x23,
    output logic [POS_W-1:0] oPosition_19x19,
    output logic [POS_W-1:0] oPosition_17x17,
    input  logic             iZs_finish,
    output logic             oBusy,
    output logic [2:0]       oOverflow,
    output logic             oTimeout
);

    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    logic [1:0] rst_sync;
    logic       rst_n;

    logic [NUM_SCALE-1:0]            valid, full, empty, push, pop, drop, dup, ready_q;
    logic [NUM_SCALE-1:0][POS_W-1:0] din, head, pos_q;
    logic [NUM_SCALE-1:0][CW-1:0]    count;

    state_t        state_q, state_d;
    logic [TW-1:0] timer_q, timer_d;
    logic          timeout_set, issue, any_queued;
    logic [2:0]    overflow_q;
    logic          timeout_q;

    // Reset asserts immediately, releases two clocks after iReset_n rises.
    always_ff @(posedge iClk or negedge iReset_n) begin
        if (!iReset_n) rst_sync <= 2'b00;
        else           rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign valid[SCALE_23] = iDet_valid_23x23;
    assign valid[SCALE_19] = iDet_valid_19x19;
    assign valid[SCALE_17] = iDet_valid_17x17;
    assign din[SCALE_23]   = iDet_pos_23x23;
    assign din[SCALE_19]   = iDet_pos_19x19;
    assign din[SCALE_17]   = iDet_pos_17x17;

    // A batch goes out only from IDLE, and never in a flush cycle.
    assign issue = (state_q == IDLE) && !iFlush && !(&empty);
    assign pop   = issue ? ~empty : '0;

    // Full FIFO still accepts when its head leaves in the same cycle.
    assign push = valid & ~dup & ~{NUM_SCALE{iFlush}} & (~full | pop);
    assign drop = valid & ~dup & ~{NUM_SCALE{iFlush}} & full & ~pop;

    for (genvar s = 0; s < NUM_SCALE; s++) begin : g_fifo
        zs_pos_fifo #(
            .DEPTH (FIFO_DEPTH),
            .W     (POS_W)
        ) u_fifo (
            .clk   (iClk),
            .rst_n (rst_n),
            .push  (push[s]),
            .pop   (pop[s]),
            .flush (iFlush),
            .din   (din[s]),
            .head  (head[s]),
            .count (count[s]),
            .full  (full[s]),
            .empty (empty[s])
        );
    end

`ifdef ZS_SCHED_DEDUP_EN
    logic [NUM_SCALE-1:0]            last_vld;
    logic [NUM_SCALE-1:0][POS_W-1:0] last_pos;

    for (genvar s = 0; s < NUM_SCALE; s++) begin : g_dup
        assign dup[s] = last_vld[s] && (last_pos[s] == din[s]);
    end

    always_ff @(posedge iClk or negedge rst_n) begin
        if (!rst_n) begin
            last_vld <= '0;
            last_pos <= '0;
        end else if (iFlush) begin
            last_vld <= '0;
        end else begin
            for (int s = 0; s < NUM_SCALE; s++) begin
                if (push[s]) begin
                    last_vld[s] <= 1'b1;
                    last_pos[s] <= din[s];
                end
            end
        end
    end
`else
    assign dup = '0;
`endif

    always_comb begin
        any_queued = 1'b0;
        for (int s = 0; s < NUM_SCALE; s++)
            any_queued = any_queued | (count[s] != '0);
    end

    always_comb begin
        state_d     = state_q;
        timer_d     = timer_q;
        timeout_set = 1'b0;
        case (state_q)
            IDLE: begin
                if (issue) begin
                    state_d = WAIT;
                    timer_d = '0;
                end
            end
            WAIT: begin
                // Finish wins over a timeout landing in the same cycle.
                if (iZs_finish) begin
                    state_d = IDLE;
                end else if (timer_q == TW'(TIMEOUT_CYC - 1)) begin
                    state_d     = IDLE;
                    timeout_set = 1'b1;
                end else begin
                    timer_d = timer_q + TW'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge iClk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            timer_q    <= '0;
            ready_q    <= '0;
            pos_q      <= '0;
            overflow_q <= '0;
            timeout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            timer_q <= timer_d;
            ready_q <= issue ? ~empty : '0;
            for (int s = 0; s < NUM_SCALE; s++)
                if (issue && !empty[s]) pos_q[s] <= head[s];
            overflow_q <= iFlush ? 3'b000 : (overflow_q | drop);
            timeout_q  <= iFlush ? 1'b0 : (timeout_q | timeout_set);
        end
    end

    assign oInput_ready_23x23 = ready_q[SCALE_23];
    assign oInput_ready_19x19 = ready_q[SCALE_19];
    assign oInput_ready_17x17 = ready_q[SCALE_17];
    assign oPosition_23x23    = pos_q[SCALE_23];
    assign oPosition_19x19    = pos_q[SCALE_19];
    assign oPosition_17x17    = pos_q[SCALE_17];
    assign oDet_full_23x23    = full[SCALE_23];
    assign oDet_full_19x19    = full[SCALE_19];
    assign oDet_full_17x17    = full[SCALE_17];
    assign oBusy              = (state_q != IDLE) || any_queued;
    assign oOverflow          = overflow_q;
    assign oTimeout           = timeout_q;

endmodule
